move_controller: RTL and testbench
==================================

Name: move_controller

Overview:
- Turn-aware mouse-to-board move sequencer. It sits directly upstream of the board-state block (chess_board).
- Converts mouse clicks on board tiles into one-cycle pick_piece / place_piece strobes plus a 6-bit figure_position for that block.
- Validates selections against side-to-move and the possible_moves mask, and tracks whose turn it is.

Parameters:
DEBOUNCE_CYCLES, 650000, cycles after any accepted click during which further clicks are ignored (0 = no lockout)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
mouse_left  input  1  left button level (already synchronised to clk)
mouse_right  input  1  right button level (cancel)
tile_valid  input  1  cursor is inside the 8x8 board area
mouse_xy  input  6  tile under cursor, [5:3] row, [2:0] column
tile_code  input  4  board code at mouse_xy (0 empty, 1-6 white, 7-C black)
pp_pos  input  6  position of last picked piece, from board block
possible_moves  input  64  legal-target mask for the held piece, bit index = {row,col}
game_over  input  1  freezes new selections while high
pick_piece  output  1  one-cycle strobe: lift piece at figure_position
place_piece  output  1  one-cycle strobe: drop held piece at figure_position
figure_position  output  6  target tile for strobes; holds last driven value otherwise
white_turn  output  1  1 = white to move
holding  output  1  high while a piece is lifted (HOLD state)
move_done  output  1  one-cycle pulse when a turn-changing placement is issued

Behaviour:
- Reset (sync, rst high at clk edge): state IDLE.
  - Outputs on reset: pick_piece=0, place_piece=0, figure_position=0, white_turn=1, holding=0, move_done=0.
  - Also on reset: lockout counter=0, edge registers=0.
- Reset mid-HOLD discards the held piece; the board block is reset by the same rst.
- Edge detect:
  - left_edge = mouse_left & ~mouse_left_q; right_edge likewise, registered one cycle.
  - An edge is accepted only if the lockout counter is 0.
  - Each accepted edge loads the counter with DEBOUNCE_CYCLES; the counter decrements to 0 and saturates there.
- Own piece: white_turn ? code in 1..6 : code in 7..C. Codes 0, D, E, F are never own.
- All outputs are registered. Strobes appear the cycle after the state that issues them is entered.
- FSM:
  - IDLE:
    - Accepted left_edge & tile_valid & own piece & ~game_over -> PICK; latch mouse_xy into sel_pos.
    - Any other edge: ignored, no lockout load.
  - PICK (1 cycle): pick_piece=1, figure_position=sel_pos -> HOLD.
  - HOLD: holding=1.
    - Accepted right_edge -> PLACE_BACK; takes priority over a simultaneous left_edge.
    - Accepted left_edge & tile_valid & mouse_xy==pp_pos -> PLACE_BACK.
    - Accepted left_edge & tile_valid & possible_moves[mouse_xy] -> PLACE_MOVE; latch target.
    - Left_edge on an illegal or off-board tile: ignored, stay in HOLD, lockout not loaded.
    - game_over does not block completing a placement.
  - PLACE_BACK (1 cycle): place_piece=1, figure_position=pp_pos, white_turn unchanged -> IDLE.
  - PLACE_MOVE (1 cycle): place_piece=1, figure_position=target, move_done=1, white_turn toggles on the same edge -> IDLE.
- pick_piece and place_piece are never high together. No pick is issued while holding=1.
- Latency, accepted click to strobe: 2 cycles (edge register + state entry).

Optional Feature:
- Macro: MOVE_COUNTER_EN.
- Defined:
  - Adds output move_count[9:0], reset to 0.
  - Increments on each move_done pulse while white_turn==0 before the toggle, i.e. counts completed full moves (black's placement).
  - Saturates at 1023.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Run all scenarios with DEBOUNCE_CYCLES=4.
- Reset, left click at tile 6'o60 with tile_code=1 -> pick_piece pulse 2 cycles later, figure_position=6'o60, holding=1.
- Holding with pp_pos=6'o60, possible_moves bit 6'o40 set, left click 6'o40 -> place_piece pulse with figure_position=6'o40, move_done=1, white_turn 1->0.
- White to move, left click on tile_code=7 -> no strobes, state stays IDLE. A second click 1 cycle later on a white piece -> accepted (lockout not loaded).
- Holding, left click on an illegal tile (mask bit 0) -> no strobe; then right click -> place_piece at pp_pos, white_turn unchanged, move_done=0.
- Holding, left and right edges in the same cycle on a legal tile -> cancel wins: place_piece at pp_pos, white_turn unchanged.
- Two accepted clicks 2 cycles apart -> second ignored. game_over=1 in IDLE with a valid own-piece click -> no pick. rst asserted during HOLD -> next cycle all outputs at reset values, white_turn=1.

Source files
------------

// File: rtl/move_controller_if.sv
// Mouse and board-block signal bundle for move_controller.
// Defining MOVE_COUNTER_EN adds the move_count output.
interface move_controller_if;
  logic         mouse_left;
  logic         mouse_right;
  logic         tile_valid;
  logic [5:0]   mouse_xy;
  logic [3:0]   tile_code;
  logic [5:0]   pp_pos;
  logic [63:0]  possible_moves;
  logic         game_over;
  logic         pick_piece;
  logic         place_piece;
  logic [5:0]   figure_position;
  logic         white_turn;
  logic         holding;
  logic         move_done;
`ifdef MOVE_COUNTER_EN
  logic [9:0]   move_count;

  modport master (
    output mouse_left, mouse_right, tile_valid, mouse_xy, tile_code,
           pp_pos, possible_moves, game_over,
    input  pick_piece, place_piece, figure_position, white_turn, holding,
           move_done, move_count
  );

  modport slave (
    input  mouse_left, mouse_right, tile_valid, mouse_xy, tile_code,
           pp_pos, possible_moves, game_over,
    output pick_piece, place_piece, figure_position, white_turn, holding,
           move_done, move_count
  );
`else
  modport master (
    output mouse_left, mouse_right, tile_valid, mouse_xy, tile_code,
           pp_pos, possible_moves, game_over,
    input  pick_piece, place_piece, figure_position, white_turn, holding,
           move_done
  );

  modport slave (
    input  mouse_left, mouse_right, tile_valid, mouse_xy, tile_code,
           pp_pos, possible_moves, game_over,
    output pick_piece, place_piece, figure_position, white_turn, holding,
           move_done
  );
`endif
endinterface

// File: rtl/move_controller.sv
// Turn-aware mouse-to-board move sequencer feeding chess_board pick/place strobes.
// Optional MOVE_COUNTER_EN adds a saturating full-move counter (move_count).
module move_controller #(
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input logic              clk,
  input logic              rst,
  move_controller_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {IDLE, PICK, HOLD, PLACE_BACK, PLACE_MOVE} state_t;

  state_t           state;
  logic             mouse_left_q, mouse_right_q;
  logic             left_edge, right_edge;
  logic [CNT_W-1:0] lockout;
  logic [5:0]       sel_pos, target_pos;
  logic             pick_piece, place_piece, white_turn, holding, move_done;
  logic [5:0]       figure_position;

  logic own_piece, left_ok, right_ok;
  logic idle_pick, hold_cancel, hold_move, load_lockout;

  assign own_piece = white_turn ? (bus.tile_code >= 4'd1 && bus.tile_code <= 4'd6)
                                : (bus.tile_code >= 4'd7 && bus.tile_code <= 4'd12);
  assign left_ok   = left_edge  && (lockout == '0);
  assign right_ok  = right_edge && (lockout == '0);

  // Cancel (right click or clicking the origin tile) outranks a legal move.
  assign idle_pick   = left_ok && bus.tile_valid && own_piece && !bus.game_over;
  assign hold_cancel = right_ok || (left_ok && bus.tile_valid && bus.mouse_xy == bus.pp_pos);
  assign hold_move   = left_ok && bus.tile_valid && bus.possible_moves[bus.mouse_xy];
  assign load_lockout = (state == IDLE && idle_pick) ||
                        (state == HOLD && (hold_cancel || hold_move));

  assign bus.pick_piece      = pick_piece;
  assign bus.place_piece     = place_piece;
  assign bus.figure_position = figure_position;
  assign bus.white_turn      = white_turn;
  assign bus.holding         = holding;
  assign bus.move_done       = move_done;

`ifdef MOVE_COUNTER_EN
  logic [9:0] move_count;
  assign bus.move_count = move_count;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mouse_left_q    <= 1'b0;
      mouse_right_q   <= 1'b0;
      left_edge       <= 1'b0;
      right_edge      <= 1'b0;
      lockout         <= '0;
      sel_pos         <= 6'd0;
      target_pos      <= 6'd0;
      pick_piece      <= 1'b0;
      place_piece     <= 1'b0;
      figure_position <= 6'd0;
      white_turn      <= 1'b1;
      holding         <= 1'b0;
      move_done       <= 1'b0;
`ifdef MOVE_COUNTER_EN
      move_count      <= 10'd0;
`endif
    end else begin
      mouse_left_q  <= bus.mouse_left;
      mouse_right_q <= bus.mouse_right;
      left_edge     <= bus.mouse_left  & ~mouse_left_q;
      right_edge    <= bus.mouse_right & ~mouse_right_q;

      if (load_lockout)
        lockout <= LOCK_LOAD;
      else if (lockout != '0)
        lockout <= lockout - CNT_W'(1);

      pick_piece  <= 1'b0;
      place_piece <= 1'b0;
      move_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (idle_pick) begin
            sel_pos <= bus.mouse_xy;
            state   <= PICK;
          end
        end
        PICK: begin
          pick_piece      <= 1'b1;
          figure_position <= sel_pos;
          holding         <= 1'b1;
          state           <= HOLD;
        end
        HOLD: begin
          if (hold_cancel) begin
            holding <= 1'b0;
            state   <= PLACE_BACK;
          end else if (hold_move) begin
            target_pos <= bus.mouse_xy;
            holding    <= 1'b0;
            state      <= PLACE_MOVE;
          end
        end
        PLACE_BACK: begin
          place_piece     <= 1'b1;
          figure_position <= bus.pp_pos;
          state           <= IDLE;
        end
        PLACE_MOVE: begin
          place_piece     <= 1'b1;
          figure_position <= target_pos;
          move_done       <= 1'b1;
          white_turn      <= ~white_turn;
`ifdef MOVE_COUNTER_EN
          // Black's placement completes a full move.
          if (!white_turn && move_count != 10'd1023)
            move_count <= move_count + 10'd1;
`endif
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: strobes are predicted into a queue and
// popped by a negedge monitor; static state is checked at fixed points.
module tb_move_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [9:0] sb_q[$];
  logic [9:0] obs_vec;

  move_controller_if bus();

  move_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign obs_vec = {bus.pick_piece, bus.place_piece, bus.figure_position,
                    bus.white_turn, bus.move_done};

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h required=%0h", tag, observed, expected);
    end
  endtask

  // Every strobe cycle must match the oldest prediction.
  always @(negedge clk) begin
    if (bus.pick_piece || bus.place_piece) begin
      checks++;
      assert (sb_q.size() != 0)
      else begin
        failures++;
        $error("[TB] FAIL unexpected_strobe observed=%0h required=none", obs_vec);
      end
      if (sb_q.size() != 0) check_output("strobe", 32'(obs_vec), 32'(sb_q.pop_front()));
    end
  end

  task automatic apply_stimulus(input logic l, input logic r, input logic [5:0] xy,
                                input logic [3:0] code, input logic valid);
    @(posedge clk); #1;
    bus.mouse_left  = l;
    bus.mouse_right = r;
    bus.mouse_xy    = xy;
    bus.tile_code   = code;
    bus.tile_valid  = valid;
    @(posedge clk); #1;
    bus.mouse_left  = 1'b0;
    bus.mouse_right = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {pick, place, figure_position, white_turn, move_done}
  function automatic logic [9:0] strobe(input logic p, input logic q, input logic [5:0] pos,
                                        input logic wt, input logic md);
    return {p, q, pos, wt, md};
  endfunction

  initial begin
    checks              = 0;
    failures            = 0;
    rst                 = 1'b1;
    bus.mouse_left      = 1'b0;
    bus.mouse_right     = 1'b0;
    bus.tile_valid      = 1'b0;
    bus.mouse_xy        = 6'd0;
    bus.tile_code       = 4'd0;
    bus.pp_pos          = 6'd0;
    bus.possible_moves  = 64'd0;
    bus.game_over       = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    check_output("rst_pick",     32'(bus.pick_piece),      32'd0);
    check_output("rst_place",    32'(bus.place_piece),     32'd0);
    check_output("rst_fig",      32'(bus.figure_position), 32'd0);
    check_output("rst_white",    32'(bus.white_turn),      32'd1);
    check_output("rst_holding",  32'(bus.holding),         32'd0);
    check_output("rst_movedone", 32'(bus.move_done),       32'd0);

    // Black piece on white's turn is ignored, so the next click is not locked out.
    apply_stimulus(1'b1, 1'b0, 6'o10, 4'd7, 1'b1);
    sb_q.push_back(strobe(1'b1, 1'b0, 6'o60, 1'b1, 1'b0));
    apply_stimulus(1'b1, 1'b0, 6'o60, 4'd1, 1'b1);
    idle(3);
    check_output("pick_holding", 32'(bus.holding), 32'd1);
    bus.pp_pos         = 6'o60;
    bus.possible_moves = 64'd1 << 6'o40;
    idle(6);

    sb_q.push_back(strobe(1'b0, 1'b1, 6'o40, 1'b0, 1'b1));
    apply_stimulus(1'b1, 1'b0, 6'o40, 4'd0, 1'b1);
    idle(3);
    check_output("move_white",   32'(bus.white_turn), 32'd0);
    check_output("move_holding", 32'(bus.holding),    32'd0);
    idle(1);
    check_output("movedone_pulse", 32'(bus.move_done), 32'd0);
    idle(6);

    // Black holds, illegal click ignored, then right-click cancel.
    sb_q.push_back(strobe(1'b1, 1'b0, 6'o10, 1'b0, 1'b0));
    apply_stimulus(1'b1, 1'b0, 6'o10, 4'd8, 1'b1);
    idle(3);
    check_output("black_holding", 32'(bus.holding), 32'd1);
    bus.pp_pos         = 6'o10;
    bus.possible_moves = 64'd1 << 6'o30;
    idle(6);
    apply_stimulus(1'b1, 1'b0, 6'o50, 4'd0, 1'b1);
    idle(8);
    check_output("illegal_holding", 32'(bus.holding), 32'd1);
    sb_q.push_back(strobe(1'b0, 1'b1, 6'o10, 1'b0, 1'b0));
    apply_stimulus(1'b0, 1'b1, 6'o50, 4'd0, 1'b1);
    idle(3);
    check_output("cancel_white", 32'(bus.white_turn), 32'd0);
    idle(6);

    // Simultaneous left+right on a legal tile: cancel wins.
    sb_q.push_back(strobe(1'b1, 1'b0, 6'o11, 1'b0, 1'b0));
    apply_stimulus(1'b1, 1'b0, 6'o11, 4'd9, 1'b1);
    idle(3);
    bus.pp_pos         = 6'o11;
    bus.possible_moves = 64'd1 << 6'o31;
    idle(6);
    sb_q.push_back(strobe(1'b0, 1'b1, 6'o11, 1'b0, 1'b0));
    apply_stimulus(1'b1, 1'b1, 6'o31, 4'd0, 1'b1);
    idle(3);
    check_output("both_white", 32'(bus.white_turn), 32'd0);
    idle(6);

    // Second click two cycles after an accepted pick falls in the lockout.
    sb_q.push_back(strobe(1'b1, 1'b0, 6'o11, 1'b0, 1'b0));
    apply_stimulus(1'b1, 1'b0, 6'o11, 4'd9, 1'b1);
    apply_stimulus(1'b1, 1'b0, 6'o31, 4'd0, 1'b1);
    idle(10);
    check_output("lockout_holding", 32'(bus.holding), 32'd1);
    sb_q.push_back(strobe(1'b0, 1'b1, 6'o11, 1'b0, 1'b0));
    apply_stimulus(1'b0, 1'b1, 6'o11, 4'd0, 1'b1);
    idle(9);

    bus.game_over = 1'b1;
    apply_stimulus(1'b1, 1'b0, 6'o12, 4'd10, 1'b1);
    idle(8);
    check_output("gameover_holding", 32'(bus.holding), 32'd0);
    bus.game_over = 1'b0;
    idle(2);

    // Reset while holding drops the piece and returns the turn to white.
    sb_q.push_back(strobe(1'b1, 1'b0, 6'o12, 1'b0, 1'b0));
    apply_stimulus(1'b1, 1'b0, 6'o12, 4'd10, 1'b1);
    idle(3);
    check_output("pre_rst_holding", 32'(bus.holding), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("hold_rst_pick",     32'(bus.pick_piece),      32'd0);
    check_output("hold_rst_place",    32'(bus.place_piece),     32'd0);
    check_output("hold_rst_fig",      32'(bus.figure_position), 32'd0);
    check_output("hold_rst_white",    32'(bus.white_turn),      32'd1);
    check_output("hold_rst_holding",  32'(bus.holding),         32'd0);
    check_output("hold_rst_movedone", 32'(bus.move_done),       32'd0);
    #1 rst = 1'b0;
    idle(3);

    check_output("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
